// File: rtl/scalar_wb_unit_pkg.sv
// Shared definitions for the scalar writeback unit.
//   reg_addr_t      : architectural register index (x0..x31)
//   DEF_DATA_WIDTH  : default result width
//   wb_src_e        : writeback source identifiers, also the arbiter index
//   NUM_WB_SRC      : number of writeback sources
package scalar_wb_unit_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int NUM_WB_SRC     = 3;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_VEC = 2'd2
  } wb_src_e;

endpackage

// File: rtl/scalar_wb_unit_rr_arbiter.sv
// wb_rr_arbiter: N-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   valid      : request per source
//   grant      : one-hot grant, combinational from valid and the pointer
// The pointer names the highest-priority source. After a grant to s it
// moves to s+1 (mod N); without any request it holds.
module wb_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/scalar_wb_unit.sv
// scalar_wb_unit: producer side of the scalar register file write port.
//   clk, rst_n                 : clock, synchronous active-low reset
//   src_valid_i/src_ready_o    : per-source valid/ready (0=ALU 1=LSU 2=VEC)
//   src_rd_i, src_data_i       : per-source destination and result
//   rd_addr_o/rd_data_o/reg_write_en_o : registered register-file write port
//   issue_valid_i, issue_rd_i  : issue stage marks issue_rd_i pending
//   rs1_addr_i, rs2_addr_i     : operands queried against the scoreboard
//   rs1_busy_o/rs2_busy_o/rd_busy_o : pending-write flags (x0 never busy)
//   pending_cnt_o              : registered count of busy registers
module scalar_wb_unit
  import scalar_wb_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_COUNT  = 32,
  parameter int NUM_SRC    = NUM_WB_SRC
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SRC-1:0]                   src_valid_i,
  output logic [NUM_SRC-1:0]                   src_ready_o,
  input  logic [NUM_SRC-1:0][4:0]              src_rd_i,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   src_data_i,
  output reg_addr_t                            rd_addr_o,
  output logic [DATA_WIDTH-1:0]                rd_data_o,
  output logic                                 reg_write_en_o,
  input  logic                                 issue_valid_i,
  input  reg_addr_t                            issue_rd_i,
  input  reg_addr_t                            rs1_addr_i,
  input  reg_addr_t                            rs2_addr_i,
  output logic                                 rs1_busy_o,
  output logic                                 rs2_busy_o,
  output logic                                 rd_busy_o,
  output logic [5:0]                           pending_cnt_o
);

  logic [NUM_SRC-1:0] grant;

  wb_rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (src_valid_i),
    .grant (grant)
  );

  // Grant is only ever raised on a valid source, so it is the transfer itself.
  assign src_ready_o = grant;

  logic                  xfer;
  reg_addr_t             sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  // One-hot AND-OR select of the granted source.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      sel_rd   = sel_rd   | (src_rd_i[s]   & {5{grant[s]}});
      sel_data = sel_data | (src_data_i[s] & {DATA_WIDTH{grant[s]}});
    end
  end

  assign xfer = |grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_en_o <= 1'b0;
      rd_addr_o      <= '0;
      rd_data_o      <= '0;
    end else begin
      // x0 results are consumed but never written.
      reg_write_en_o <= xfer && (sel_rd != '0);
      if (xfer) begin
        rd_addr_o <= sel_rd;
        rd_data_o <= sel_data;
      end
    end
  end

  // Scoreboard. The clear is applied before the set so that a new producer
  // issued in the same cycle as the old one retires keeps the bit pending.
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [5:0]           cnt_d;

  always_comb begin
    busy_d = busy_q;
    if (reg_write_en_o) busy_d[rd_addr_o] = 1'b0;
    if (issue_valid_i && (issue_rd_i != '0)) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int r = 0; r < REG_COUNT; r++) cnt_d = cnt_d + 6'(busy_d[r]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q        <= '0;
      pending_cnt_o <= '0;
    end else begin
      busy_q        <= busy_d;
      pending_cnt_o <= cnt_d;
    end
  end

  // busy_q[0] is held at 0, so address 0 reads as not busy.
  assign rs1_busy_o = busy_q[rs1_addr_i];
  assign rs2_busy_o = busy_q[rs2_addr_i];
  assign rd_busy_o  = busy_q[issue_rd_i];

endmodule

// File: tb/tb_scalar_wb_unit.sv
module tb_scalar_wb_unit;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        valid;
  logic [2:0]        ready;
  logic [2:0][4:0]   src_rd;
  logic [2:0][31:0]  src_data;
  logic [4:0]        rd_addr;
  logic [31:0]       rd_data;
  logic              wen;
  logic              issue_valid;
  logic [4:0]        issue_rd, rs1, rs2;
  logic              rs1_busy, rs2_busy, rd_busy;
  logic [5:0]        pcnt;

  always #5 clk = ~clk;

  scalar_wb_unit dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(valid), .src_ready_o(ready),
    .src_rd_i(src_rd), .src_data_i(src_data),
    .rd_addr_o(rd_addr), .rd_data_o(rd_data), .reg_write_en_o(wen),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy), .rd_busy_o(rd_busy),
    .pending_cnt_o(pcnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: priority pointer, set of pending registers, write port.
  int       m_ptr;
  bit       m_busy [32];
  bit       m_en;
  int       m_addr;
  logic [31:0] m_data;
  int       m_cnt;
  int       m_last_g;

  function automatic int mgrant(logic [2:0] v, int p);
    for (int k = 0; k < 3; k++)
      if (v[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  function automatic bit mbusy(int a);
    return (a != 0) && m_busy[a];
  endfunction

  function automatic logic [2:0] mready();
    int g;
    g = mgrant(valid, m_ptr);
    return (g < 0) ? 3'b000 : 3'(1 << g);
  endfunction

  // Advance the model across one rising edge using the inputs present there.
  task automatic model_step();
    int g;
    if (!rst_n) begin
      m_ptr = 0; m_en = 0; m_addr = 0; m_data = 0; m_last_g = -1;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      g = mgrant(valid, m_ptr);
      if (m_en) m_busy[m_addr] = 0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
      m_last_g = g;
      if (g >= 0) begin
        m_addr = src_rd[g];
        m_data = src_data[g];
        m_en   = (src_rd[g] != 0);
        m_ptr  = (g + 1) % 3;
      end else m_en = 0;
    end
    m_cnt = 0;
    foreach (m_busy[i]) m_cnt += m_busy[i];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid = 0; issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    for (int s = 0; s < 3; s++) begin src_rd[s] = 0; src_data[s] = 0; end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      rs1 = 5'(c); rs2 = 5'(31 - c); issue_rd = 5'(c + 3);
      #1;
      n_cmp++;
      if (wen !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 ||
          rd_busy !== 1'b0 || pcnt !== 6'd0 || ready !== 3'b000 ||
          rd_addr !== 5'd0 || rd_data !== 32'd0) begin
        n_err++;
        $display("FAIL reset_idle c=%0d: en=%b busy=%b%b%b cnt=%0d rdy=%b addr=%0d data=%h, want all 0",
                 c, wen, rs1_busy, rs2_busy, rd_busy, pcnt, ready, rd_addr, rd_data);
      end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    issue_valid = 1; issue_rd = 5;
    tick();
    issue_valid = 0; issue_rd = 0; rs1 = 5;
    #1; n_cmp++;
    if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL single_busy_pre got=%b want=1", rs1_busy); end
    tick();
    valid = 3'b001; src_rd[0] = 5; src_data[0] = 32'hDEADBEEF;
    #1; n_cmp++;
    if (ready !== 3'b001) begin n_err++; $display("FAIL single_ready got=%b want=001", ready); end
    tick();
    valid = 0;
    #1; n_cmp++;
    if (wen !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF || rs1_busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_write en=%b addr=%0d data=%h busy=%b want 1/5/deadbeef/1", wen, rd_addr, rd_data, rs1_busy);
    end
    tick();
    #1; n_cmp++;
    if (rs1_busy !== 1'b0 || wen !== 1'b0 || pcnt !== 6'd0) begin
      n_err++;
      $display("FAIL single_clear busy=%b en=%b cnt=%0d want 0/0/0", rs1_busy, wen, pcnt);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    valid = 3'b111;
    for (int s = 0; s < 3; s++) src_rd[s] = 5'(s + 1);
    for (int c = 0; c < 9; c++) begin
      for (int s = 0; s < 3; s++) src_data[s] = $urandom;
      #1; n_cmp++;
      if (ready !== 3'(1 << (c % 3)) || ready !== mready()) begin
        n_err++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, ready, 3'(1 << (c % 3)));
      end
      if (c > 0) begin
        n_cmp++;
        if (wen !== 1'b1 || rd_addr !== 5'(((c - 1) % 3) + 1)) begin
          n_err++; $display("FAIL rr_write c=%0d en=%b addr=%0d want 1/%0d", c, wen, rd_addr, ((c - 1) % 3) + 1);
        end
      end
      tick();
    end
    valid = 0;
  endtask

  task automatic test_x0();
    do_reset();
    valid = 3'b010; src_rd[1] = 0; src_data[1] = 32'h1234;
    issue_valid = 1; issue_rd = 0;
    #1; n_cmp++;
    if (ready !== 3'b010) begin n_err++; $display("FAIL x0_ready got=%b want=010", ready); end
    tick();
    valid = 0; issue_valid = 0;
    #1; n_cmp++;
    if (wen !== 1'b0 || pcnt !== 6'd0 || rd_busy !== 1'b0) begin
      n_err++; $display("FAIL x0_write en=%b cnt=%0d rd_busy=%b want 0/0/0", wen, pcnt, rd_busy);
    end
    tick();
  endtask

  task automatic test_set_clear();
    do_reset();
    issue_valid = 1; issue_rd = 7;
    tick();
    issue_valid = 0;
    valid = 3'b100; src_rd[2] = 7; src_data[2] = 32'hCAFE0007;
    tick();
    valid = 0; issue_valid = 1; issue_rd = 7; rs1 = 7;
    #1; n_cmp++;
    if (wen !== 1'b1 || rd_addr !== 5'd7 || pcnt !== 6'd1 || rd_busy !== 1'b1) begin
      n_err++; $display("FAIL setclr_pre en=%b addr=%0d cnt=%0d rd_busy=%b want 1/7/1/1", wen, rd_addr, pcnt, rd_busy);
    end
    tick();
    issue_valid = 0;
    #1; n_cmp++;
    if (rs1_busy !== 1'b1 || pcnt !== 6'd1) begin
      n_err++; $display("FAIL setclr_post busy=%b cnt=%0d want 1/1", rs1_busy, pcnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_valid = 1; issue_rd = 9;
    tick();
    issue_valid = 0;
    valid = 3'b010; src_rd[1] = 9; src_data[1] = 32'h99;
    tick();  // pointer now 2, write to x9 in flight
    valid = 0; rst_n = 0;
    tick();
    rst_n = 1; rs1 = 9;
    #1; n_cmp++;
    if (wen !== 1'b0 || pcnt !== 6'd0 || rs1_busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_state en=%b cnt=%0d busy=%b want 0/0/0", wen, pcnt, rs1_busy);
    end
    valid = 3'b111;
    #1; n_cmp++;
    if (ready !== 3'b001) begin n_err++; $display("FAIL rstmid_ptr got=%b want=001", ready); end
    tick();
    valid = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 3; s++) begin
        // A source that was waiting keeps its request stable.
        if (!(valid[s] && m_last_g != s)) begin
          valid[s]    = ($urandom_range(0, 2) != 0);
          src_rd[s]   = (($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
          src_data[s] = $urandom;
        end
      end
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      if (c == 200) rst_n = 0;
      else rst_n = 1;
      #1; n_cmp++;
      if (ready !== mready() || wen !== m_en || rd_addr !== 5'(m_addr) ||
          rd_data !== m_data || pcnt !== 6'(m_cnt) ||
          rs1_busy !== mbusy(rs1) || rs2_busy !== mbusy(rs2) || rd_busy !== mbusy(issue_rd)) begin
        n_err++;
        $display("FAIL random c=%0d rdy=%b/%b en=%b/%b addr=%0d/%0d data=%h/%h cnt=%0d/%0d busy=%b%b%b/%b%b%b",
                 c, ready, mready(), wen, m_en, rd_addr, m_addr, rd_data, m_data, pcnt, m_cnt,
                 rs1_busy, rs2_busy, rd_busy, mbusy(rs1), mbusy(rs2), mbusy(issue_rd));
      end
      tick();
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    m_last_g = -1;
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_set_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
